serial_operand_tx: RTL and testbench

SERIAL_OPERAND_TX -- requirements
Module: serial_operand_tx

---
 rtl/serial_operand_tx.sv | 142 ++++++++++++++
 tb/tb_serial_operand_tx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand feeder for a bit-serial adder: captures an a/b pair,
// streams it one bit per cycle with first/last framing, then pulses done.
// Bit order: LSB first by default; define SERIAL_MSB_FIRST_EN for MSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for in_valid; in_ready=1, serial outputs low
// S_SHIFT | one operand bit per cycle on a/b with bit_valid=1
// S_DONE  | single cycle after the last bit; done=1, in_ready=0
module serial_operand_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             a,
   output logic             b,
   output logic             bit_valid,
   output logic             first,
   output logic             last,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

`ifdef SERIAL_MSB_FIRST_EN
   localparam int HEAD = WIDTH - 1;
`else
   localparam int HEAD = 0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [WIDTH-1:0] sr_a;
   logic [WIDTH-1:0] sr_b;
   logic [CW-1:0]    cnt;

   // Move the next bit to emit into the HEAD position.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
`ifdef SERIAL_MSB_FIRST_EN
      return v << 1;
`else
      return v >> 1;
`endif
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         sr_a      <= '0;
         sr_b      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         a         <= 1'b0;
         b         <= 1'b0;
         bit_valid <= 1'b0;
         first     <= 1'b0;
         last      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               a         <= 1'b0;
               b         <= 1'b0;
               bit_valid <= 1'b0;
               first     <= 1'b0;
               last      <= 1'b0;
               done      <= 1'b0;
               in_ready  <= 1'b1;
               if (in_valid && in_ready) begin
                  // Bit 0 of the word is presented straight off the handshake edge.
                  sr_a      <= advance(a_in);
                  sr_b      <= advance(b_in);
                  a         <= a_in[HEAD];
                  b         <= b_in[HEAD];
                  bit_valid <= 1'b1;
                  first     <= 1'b1;
                  cnt       <= '0;
                  in_ready  <= 1'b0;
                  state     <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               first    <= 1'b0;
               in_ready <= 1'b0;
               if (cnt == CNT_LAST) begin
                  a         <= 1'b0;
                  b         <= 1'b0;
                  bit_valid <= 1'b0;
                  last      <= 1'b0;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  // cnt tracks the bit index currently on a/b.
                  cnt       <= cnt + 1'b1;
                  a         <= sr_a[HEAD];
                  b         <= sr_b[HEAD];
                  sr_a      <= advance(sr_a);
                  sr_b      <= advance(sr_b);
                  bit_valid <= 1'b1;
                  last      <= (cnt == CNT_PRE);
               end
            end

            S_DONE: begin
               a         <= 1'b0;
               b         <= 1'b0;
               bit_valid <= 1'b0;
               first     <= 1'b0;
               last      <= 1'b0;
               done      <= 1'b0;
               in_ready  <= 1'b1;
               state     <= S_IDLE;
            end

            default: begin
               a         <= 1'b0;
               b         <= 1'b0;
               bit_valid <= 1'b0;
               first     <= 1'b0;
               last      <= 1'b0;
               done      <= 1'b0;
               in_ready  <= 1'b1;
               cnt       <= '0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_operand_tx.sv
// Randomized self-checking bench for serial_operand_tx against a word-level
// model: expected bit order, framing cycle numbers and a serial-adder sum.
module tb_serial_operand_tx;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         in_ready, a, b, bit_valid, first, last, done;

   int checks = 0;
   int errors = 0;

   serial_operand_tx #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .a(a), .b(b), .bit_valid(bit_valid),
      .first(first), .last(last), .done(done)
   );

   always #5 clk = ~clk;

   // Operand bit index carried on the k-th serial cycle (k = 0..W-1).
   function automatic int ord(input int k);
`ifdef SERIAL_MSB_FIRST_EN
      return W - 1 - k;
`else
      return k;
`endif
   endfunction

   // Expected {a,b,bit_valid,first,last,done,in_ready} on cycle c after a handshake.
   function automatic logic [6:0] model(input logic [W-1:0] wa, input logic [W-1:0] wb, input int c);
      if (c >= 1 && c <= W)
         return {wa[ord(c-1)], wb[ord(c-1)], 1'b1, (c == 1), (c == W), 1'b0, 1'b0};
      else if (c == W + 1)
         return 7'b0000010;
      return 7'b0000001;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      reset_n = 1'b0;
      in_valid = 1'b1;
      a_in = 8'hFF;
      b_in = 8'hFF;
      repeat (3) tick();
      obs = {a, b, bit_valid, first, last, done, in_ready};
      checks++;
      if (obs !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_hold: outputs=%b required %b", obs, 7'b0000001);
      end
      in_valid = 1'b0;
      reset_n = 1'b1;
      repeat (2) tick();
      obs = {a, b, bit_valid, first, last, done, in_ready};
      checks++;
      if (obs !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_release: outputs=%b required %b", obs, 7'b0000001);
      end
   endtask

   task automatic test_vector_a5();
      logic [6:0] obs, exp;
      wait_ready();
      a_in = 8'hA5;
      b_in = 8'h3C;
      in_valid = 1'b1;
      for (int c = 1; c <= W + 2; c++) begin
         tick();
         in_valid = 1'b0;
         obs = {a, b, bit_valid, first, last, done, in_ready};
         exp = model(8'hA5, 8'h3C, c);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL a5_cycle%0d: outputs=%b required %b", c, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int first_cyc[$];
      int ready_cyc[$];
      logic [W-1:0] got_a [2];
      int widx = -1;
      int k = 0;
      wait_ready();
      a_in = 8'h01;
      b_in = 8'h01;
      in_valid = 1'b1;
      got_a[0] = '0;
      got_a[1] = '0;
      for (int c = 1; c <= 21; c++) begin
         tick();
         a_in = 8'hFF;
         b_in = 8'hFF;
         if (c == 12) in_valid = 1'b0;
         if (first) begin
            first_cyc.push_back(c);
            widx++;
            k = 0;
         end
         if (in_ready) ready_cyc.push_back(c);
         if (bit_valid && widx >= 0 && widx < 2) begin
            got_a[widx][ord(k)] = a;
            k++;
         end
      end
      checks++;
      if (first_cyc.size() != 2 || first_cyc[0] != 1 || first_cyc[1] - first_cyc[0] != W + 2) begin
         errors++;
         $display("FAIL b2b_first_spacing: first pulses=%0d at %p required 2 at cycles 1 and %0d",
                  first_cyc.size(), first_cyc, W + 3);
      end
      checks++;
      if (ready_cyc.size() < 1 || ready_cyc[0] != W + 2) begin
         errors++;
         $display("FAIL b2b_handshake: in_ready cycles %p required first at %0d", ready_cyc, W + 2);
      end
      checks++;
      if (got_a[0] !== 8'h01 || got_a[1] !== 8'hFF) begin
         errors++;
         $display("FAIL b2b_words: got %h,%h required 01,ff", got_a[0], got_a[1]);
      end
      repeat (W + 2) tick();
   endtask

   task automatic test_toggle();
      logic [W-1:0] wa, wb;
      logic [6:0] obs, exp;
      int bad = 0;
      wait_ready();
      wa = W'($urandom);
      wb = W'($urandom);
      a_in = wa;
      b_in = wb;
      in_valid = 1'b1;
      for (int c = 1; c <= W + 2; c++) begin
         tick();
         a_in = W'($urandom);
         b_in = W'($urandom);
         in_valid = (c < W + 1);
         obs = {a, b, bit_valid, first, last, done, in_ready};
         exp = model(wa, wb, c);
         if (obs !== exp) begin
            bad++;
            $display("FAIL toggle_cycle%0d: outputs=%b required %b", c, obs, exp);
         end
      end
      checks++;
      if (bad != 0) errors++;
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] wa, wb;
      logic [6:0] obs, exp;
      int extra = 0;
      wait_ready();
      wa = W'($urandom);
      wb = W'($urandom);
      a_in = wa;
      b_in = wb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      // bit 4 on the outputs now
      reset_n = 1'b0;
      #1;
      obs = {a, b, bit_valid, first, last, done, in_ready};
      checks++;
      if (obs !== 7'b0000001) begin
         errors++;
         $display("FAIL rst_mid_immediate: outputs=%b required %b", obs, 7'b0000001);
      end
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < W + 3; c++) begin
         tick();
         if (bit_valid || done || first || last || !in_ready) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL rst_mid_residue: %0d active cycles after reset, required 0", extra);
      end
      wa = W'($urandom);
      wb = W'($urandom);
      a_in = wa;
      b_in = wb;
      in_valid = 1'b1;
      for (int c = 1; c <= W + 2; c++) begin
         tick();
         in_valid = 1'b0;
         obs = {a, b, bit_valid, first, last, done, in_ready};
         exp = model(wa, wb, c);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL rst_mid_new_cycle%0d: outputs=%b required %b", c, obs, exp);
         end
      end
   endtask

`ifdef SERIAL_MSB_FIRST_EN
   task automatic test_msb_first();
      wait_ready();
      a_in = 8'h80;
      b_in = 8'h00;
      in_valid = 1'b1;
      for (int c = 1; c <= W; c++) begin
         tick();
         in_valid = 1'b0;
         checks++;
         if (a !== (c == 1)) begin
            errors++;
            $display("FAIL msb_cycle%0d: a=%b required %b", c, a, (c == 1));
         end
      end
      repeat (3) tick();
   endtask
`endif

   task automatic test_random_adder();
      logic [W-1:0] wa, wb, ra, rb, sum;
      logic carry;
      int nbits, done_at, last_at, first_at, bad;
      bad = 0;
      for (int n = 0; n < 1000; n++) begin
         wait_ready();
         if ($urandom_range(0, 3) == 0) tick();
         wa = W'($urandom);
         wb = W'($urandom);
         a_in = wa;
         b_in = wb;
         in_valid = 1'b1;
         ra = '0; rb = '0; sum = '0; carry = 1'b0;
         nbits = 0; done_at = 0; last_at = 0; first_at = 0;
         for (int c = 1; c <= W + 1; c++) begin
            tick();
            in_valid = 1'b0;
            a_in = W'($urandom);
            b_in = W'($urandom);
            if (first) begin
               carry = 1'b0;
               first_at = c;
            end
            if (bit_valid && nbits < W) begin
               ra[ord(nbits)] = a;
               rb[ord(nbits)] = b;
               sum[ord(nbits)] = a ^ b ^ carry;
               carry = (a & b) | (a & carry) | (b & carry);
               nbits++;
            end
            if (last) last_at = c;
            if (done) done_at = c;
         end
         if (ra !== wa || rb !== wb || nbits != W || first_at != 1 || last_at != W || done_at != W + 1) begin
            bad++;
            if (bad <= 5)
               $display("FAIL rand_word%0d: a=%h b=%h bits=%0d first@%0d last@%0d done@%0d required a=%h b=%h bits=%0d 1 %0d %0d",
                        n, ra, rb, nbits, first_at, last_at, done_at, wa, wb, W, W, W + 1);
         end
`ifndef SERIAL_MSB_FIRST_EN
         if (sum !== W'(wa + wb)) begin
            bad++;
            if (bad <= 5)
               $display("FAIL rand_sum%0d: sum=%h required %h", n, sum, W'(wa + wb));
         end
`endif
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rand_total: %0d bad words, required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_vector_a5();
      test_back_to_back();
      test_toggle();
      test_reset_mid();
`ifdef SERIAL_MSB_FIRST_EN
      test_msb_first();
`endif
      test_random_adder();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
